keccak_block_padder: RTL and testbench

//   Upstream neighbour of the SHA3 f_permutation stage. Packs 32-bit message words into
//   576-bit rate blocks, applies SHA3 multi-rate padding (0x06 ... 0x80) after the last

---
 rtl/keccak_block_padder.sv | 113 +++++++++++
 tb/tb_keccak_block_padder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_block_padder.sv
// Packs message words into rate blocks and applies SHA3 multi-rate padding after the last byte.
// Latency: out_ready rises 1 + (WORDS - cnt_after_last_accept) cycles after the last word is taken.
// Backpressure: buffer_full holds the source off outside FILL; a word offered then is dropped and must be held.
module keccak_block_padder #(
    parameter int          RATE_BITS = 576,
    parameter int          WORD_W    = 32,
    parameter logic [7:0]  DOMAIN    = 8'h06
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_W-1:0]     in,
    input  logic                  in_ready,
    input  logic                  is_last,
    input  logic [1:0]            byte_num,
    output logic                  buffer_full,
    output logic [RATE_BITS-1:0]  out,
    output logic                  out_ready,
    input  logic                  f_ack
);

    localparam int WORDS = RATE_BITS / WORD_W;
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] WORDS_CNT = CNT_W'(WORDS);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        FULL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              pad_done, pad_done_nxt;
    logic              shift_en;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] data_mask;
    logic [WORD_W-1:0] dom_word;
    logic [WORD_W-1:0] last_word;

    assign buffer_full = (state != FILL);

    // Keep the first byte_num bytes, then the domain byte, zeros after it.
    always_comb begin
        data_mask = ~({WORD_W{1'b1}} >> (8 * byte_num));
        dom_word  = {DOMAIN, {(WORD_W-8){1'b0}}} >> (8 * byte_num);
        last_word = (in & data_mask) | dom_word;
        if (cnt == LAST_IDX) begin
            last_word[7:0] = last_word[7:0] | 8'h80;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pad_done_nxt = pad_done;
        shift_en     = 1'b0;
        word         = '0;
        case (state)
            FILL: begin
                if (in_ready) begin
                    shift_en = 1'b1;
                    cnt_nxt  = cnt + 1'b1;
                    if (is_last) begin
                        word         = last_word;
                        pad_done_nxt = 1'b1;
                        state_nxt    = (cnt_nxt == WORDS_CNT) ? FULL : PAD;
                    end else begin
                        word      = in;
                        state_nxt = (cnt_nxt == WORDS_CNT) ? FULL : FILL;
                    end
                end
            end
            PAD: begin
                shift_en = 1'b1;
                cnt_nxt  = cnt + 1'b1;
                if (cnt == LAST_IDX) begin
                    word      = {{(WORD_W-8){1'b0}}, 8'h80};
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (f_ack) begin
                    cnt_nxt   = '0;
                    state_nxt = pad_done ? DONE : FILL;
                end
            end
            default: begin
                state_nxt = DONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FILL;
            cnt       <= '0;
            pad_done  <= 1'b0;
            out       <= '0;
            out_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pad_done  <= pad_done_nxt;
            out_ready <= (state_nxt == FULL);
            if (shift_en) begin
                out <= {out[RATE_BITS-WORD_W-1:0], word};
            end
        end
    end

endmodule

// File: tb/tb_keccak_block_padder.sv
// Directed bench for keccak_block_padder: byte-level padding model feeds a block scoreboard.
module tb_keccak_block_padder;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  in_w;
    logic         in_ready;
    logic         is_last;
    logic [1:0]   byte_num;
    logic         buffer_full;
    logic [575:0] out;
    logic         out_ready;
    logic         f_ack;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [575:0] exp_q[$];
    logic [575:0] last_block;

    keccak_block_padder dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in_w),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .buffer_full (buffer_full),
        .out         (out),
        .out_ready   (out_ready),
        .f_ack       (f_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one message of len bytes (bytes given by first_bytes, then pseudo-random),
    // acks each block ack_delay cycles after it appears, optionally offering words while FULL.
    task automatic run_msg(input int len, input logic [23:0] first_bytes, input int ack_delay,
                           input bit hold_in);
        logic [7:0]  msg[$];
        logic [7:0]  pad[$];
        logic [31:0] words[$];
        logic [575:0] blk;
        logic [575:0] cur_exp;
        int nwords, widx, wait_cnt, cyc, lat_cnt, lat_exp;
        bit lat_active, just_acked;

        msg.delete(); pad.delete(); words.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 3) msg.push_back(first_bytes[23-8*i -: 8]);
            else       msg.push_back(8'($urandom));
        end
        foreach (msg[i]) pad.push_back(msg[i]);
        pad.push_back(8'h06);
        while (pad.size() % 72 != 0) pad.push_back(8'h00);
        pad[pad.size()-1] = pad[pad.size()-1] | 8'h80;
        for (int b = 0; b < pad.size() / 72; b++) begin
            blk = '0;
            for (int i = 0; i < 72; i++) blk[575-8*i -: 8] = pad[b*72+i];
            exp_q.push_back(blk);
        end
        nwords = len / 4 + 1;
        for (int w = 0; w < nwords; w++) begin
            logic [31:0] wd;
            for (int k = 0; k < 4; k++) begin
                if (4*w + k < len) wd[31-8*k -: 8] = msg[4*w+k];
                else               wd[31-8*k -: 8] = 8'($urandom);
            end
            words.push_back(wd);
        end

        widx = 0; wait_cnt = 0; cyc = 0; lat_cnt = 0; lat_exp = 0;
        lat_active = 0; just_acked = 0; cur_exp = '0;
        while (cyc < 3000 && !(widx == nwords && exp_q.size() == 0)) begin
            @(negedge clk);
            cyc++;
            in_ready = 1'b0;
            f_ack    = 1'b0;
            is_last  = 1'b0;
            if (just_acked) begin
                chk("post_ack_out_ready", out_ready, 1'b0);
                chk("post_ack_buffer_full", buffer_full, (widx == nwords) ? 1'b1 : 1'b0);
                just_acked = 0;
            end
            if (lat_active) begin
                lat_cnt++;
                if (out_ready) begin
                    chk("last_word_latency", lat_cnt, lat_exp);
                    lat_active = 0;
                end
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_block", 1'b1, 1'b0);
                    f_ack = 1'b1;
                end else begin
                    cur_exp = exp_q[0];
                    chk("block", out, cur_exp);
                    chk("full_buffer_full", buffer_full, 1'b1);
                    if (wait_cnt == ack_delay) begin
                        last_block = out;
                        void'(exp_q.pop_front());
                        f_ack      = 1'b1;
                        wait_cnt   = 0;
                        just_acked = 1;
                    end else begin
                        wait_cnt++;
                        if (hold_in) begin
                            in_ready = 1'b1;
                            in_w     = $urandom;
                            is_last  = 1'($urandom);
                            byte_num = 2'($urandom);
                        end
                    end
                end
            end else if (!buffer_full && widx < nwords) begin
                in_w     = words[widx];
                in_ready = 1'b1;
                byte_num = 2'($urandom);
                if (widx == nwords - 1) begin
                    is_last    = 1'b1;
                    byte_num   = 2'(len % 4);
                    lat_active = 1;
                    lat_cnt    = 0;
                    lat_exp    = 18 - (widx % 18);
                end
                widx++;
            end
        end
        if (cyc >= 3000) chk("message_timeout", 1'b1, 1'b0);

        @(negedge clk);
        in_ready = 1'b0;
        f_ack    = 1'b0;
        chk("done_out_ready", out_ready, 1'b0);
        chk("done_buffer_full", buffer_full, 1'b1);
        // DONE must ignore both new words and stray acks.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_ready = 1'b1;
            is_last  = 1'b1;
            in_w     = $urandom;
            f_ack    = 1'b1;
        end
        @(negedge clk);
        in_ready = 1'b0;
        f_ack    = 1'b0;
        chk("done_hold_out_ready", out_ready, 1'b0);
        chk("done_hold_buffer_full", buffer_full, 1'b1);
        chk("done_hold_out", out, last_block);

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rearm_buffer_full", buffer_full, 1'b0);
    endtask

    initial begin
        reset    = 1'b0;
        in_w     = '0;
        in_ready = 1'b0;
        is_last  = 1'b0;
        byte_num = '0;
        f_ack    = 1'b0;
        last_block = '0;
        #1;
        chk("reset_out", out, '0);
        chk("reset_out_ready", out_ready, 1'b0);
        chk("reset_buffer_full", buffer_full, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Empty message.
        run_msg(0, 24'h0, 0, 0);
        chk("empty_word0", last_block[575:544], 32'h06000000);
        chk("empty_word17", last_block[31:0], 32'h00000080);

        // "abc".
        run_msg(3, 24'h616263, 2, 0);
        chk("abc_word0", last_block[575:544], 32'h61626306);
        chk("abc_word17", last_block[31:0], 32'h00000080);

        // 72 bytes: raw block, then a pad-only block; words offered while FULL.
        run_msg(72, 24'h010203, 5, 1);
        chk("len72_pad_word0", last_block[575:544], 32'h06000000);

        // 71 bytes: pad fits in the last word.
        run_msg(71, 24'hAABBCC, 1, 0);
        chk("len71_word17_low", last_block[7:0], 8'h86);

        run_msg(13, 24'h112233, 3, 1);
        run_msg(150, 24'h445566, 0, 1);

        // Reset asserted between edges while PAD is inserting words.
        @(negedge clk);
        in_w = 32'hDEADBEEF; in_ready = 1'b1; is_last = 1'b0;
        @(negedge clk);
        in_w = 32'hCAFE0000; in_ready = 1'b1; is_last = 1'b1; byte_num = 2'd1;
        @(negedge clk);
        in_ready = 1'b0; is_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pad_buffer_full", buffer_full, 1'b1);
        chk("pad_out_ready", out_ready, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_out", out, '0);
        chk("async_out_ready", out_ready, 1'b0);
        chk("async_buffer_full", buffer_full, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        run_msg(5, 24'h776655, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
